clock_ctrl: RTL and testbench
=============================

Name: clock_ctrl

Overview:
- Time-of-day controller for the clock1 design: keeps HH:MM:SS in BCD, runs a set-mode state machine driven by two push-buttons, and selects which four BCD digits feed the four per-digit seven-segment decoders (HEX3..HEX0).
- A blanked digit is driven as 4'hF; the decoder maps any non-0..9 code to all segments off.

Parameters:
- CLK_HZ, 50000000, input clock frequency; one-second tick period in cycles. Must be even and >= 2.

Ports:
- CLK  in  1  system clock.
- RST  in  1  synchronous, active-high reset.
- KEY_MODE  in  1  mode button, active-high level, already debounced and synchronized to CLK.
- KEY_INC  in  1  increment button, active-high level, already debounced and synchronized to CLK.
- DISP  in  1  display select in RUN: 0 = HH:MM, 1 = MM:SS.
- DIG3  out  4  leftmost BCD digit or 4'hF (blank).
- DIG2  out  4  BCD digit or 4'hF.
- DIG1  out  4  BCD digit or 4'hF.
- DIG0  out  4  rightmost BCD digit or 4'hF.
- COLON  out  1  colon/separator LED, active-high.
- MODE  out  2  current state: 0 = RUN, 1 = SET_HOUR, 2 = SET_MIN.

Behaviour:
- Reset (RST=1 at a CLK edge):
  - state=RUN, time=00:00:00, prescaler=0, button edge registers=0.
  - Outputs the cycle after reset: DIG3..DIG0 = 0,0,0,0; COLON=1; MODE=0.
- Prescaler:
  - Counts 0..CLK_HZ-1 and wraps; runs in every state.
  - tick is asserted when prescaler == CLK_HZ-1.
  - half is asserted when prescaler >= CLK_HZ/2.
- Button edges: each button has a registered previous value; press = level & ~prev. A held button produces exactly one press.
- RUN timekeeping: on tick, seconds +1.
  - Seconds 59 -> 00 carries into minutes; minutes 59 -> 00 carries into hours; hours 23 -> 00.
  - 23:59:59 -> 00:00:00 in a single tick.
  - Digits are held as BCD tens/units pairs; a units digit never exceeds 9.
- State machine (transitions on a mode press):
  - RUN -> SET_HOUR.
  - SET_HOUR -> SET_MIN.
  - SET_MIN -> RUN. On this transition seconds are cleared to 00 and the prescaler to 0, so the first tick comes CLK_HZ cycles later.
- Increment presses:
  - SET_HOUR: hours +1, 23 -> 00.
  - SET_MIN: minutes +1, 59 -> 00, no carry into hours.
  - RUN: ignored.
- While in SET_HOUR or SET_MIN, tick does not advance time.
- Simultaneous mode and inc presses in the same cycle: mode wins, inc is discarded.
- Display (combinational from registered state, zero added latency):
  - RUN, DISP=0: DIG3..0 = hour tens, hour units, minute tens, minute units.
  - RUN, DISP=1: DIG3..0 = minute tens, minute units, second tens, second units.
  - SET states: HH:MM is forced regardless of DISP. The field being set (hours in SET_HOUR = DIG3/DIG2; minutes in SET_MIN = DIG1/DIG0) is 4'hF while half=1. The other field is always shown.
  - No leading-zero suppression; hour tens shows 0.
- COLON: RUN = ~half (on for the first half of each second); SET states = 1.
- MODE: state encoding, valid the cycle after each transition.
- Reset mid-operation (any state, including during a carry cycle): all state returns to reset values at that edge, and no button press is generated from buttons held through reset.

Test Plan:
- CLK_HZ=4; reset, then release RST and run 4 cycles -> seconds 00 -> 01 on the 4th edge. DISP=1 shows DIG=0,0,0,1. COLON pattern over one second is 1,1,0,0.
- CLK_HZ=4; set hours to 23 and minutes to 59 via SET mode and return to RUN, then run 59 ticks -> 23:59:59. One more tick -> DIG (DISP=0) = 0,0,0,0 and seconds 00.
- Mode press then 25 inc presses in SET_HOUR -> hours 01 (wrap at 23 -> 00). DIG3/DIG2 read F,F while half=1 and 0,1 while half=0; COLON=1 throughout.
- In SET_MIN at minutes 59, one inc press -> minutes 00, hours unchanged. Mode press -> RUN with seconds=00, prescaler=0, and the next tick exactly 4 cycles later.
- KEY_MODE and KEY_INC rise in the same cycle in SET_HOUR -> state SET_MIN, hours unchanged. Holding KEY_INC high for 10 cycles yields exactly one increment.
- RST asserted in SET_MIN with KEY_MODE held high through and after reset -> MODE=0, time 00:00:00, no transition until KEY_MODE falls and rises again.

Source files
------------

// File: rtl/clock_ctrl.sv
// Time-of-day controller: BCD HH:MM:SS timekeeping, two-button set-mode FSM,
// and selection of the four digits shown on the seven-segment display.
module clock_ctrl #(
  parameter int CLK_HZ = 50000000
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       KEY_MODE,
  input  logic       KEY_INC,
  input  logic       DISP,
  output logic [3:0] DIG3,
  output logic [3:0] DIG2,
  output logic [3:0] DIG1,
  output logic [3:0] DIG0,
  output logic       COLON,
  output logic [1:0] MODE
);

  localparam int PW = (CLK_HZ > 2) ? $clog2(CLK_HZ) : 1;
  localparam logic [PW-1:0] TICK_VAL = PW'(CLK_HZ - 1);
  localparam logic [PW-1:0] HALF_VAL = PW'(CLK_HZ / 2);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    SET_HOUR = 2'd1,
    SET_MIN  = 2'd2
  } state_t;

  state_t        state_reg, state_next;
  logic [PW-1:0] pre_reg, pre_next;
  logic [3:0]    hr_t_reg, hr_u_reg, mn_t_reg, mn_u_reg, sc_t_reg, sc_u_reg;
  logic [3:0]    hr_t_next, hr_u_next, mn_t_next, mn_u_next, sc_t_next, sc_u_next;
  logic          mode_prev_reg, inc_prev_reg, boot_reg;

  logic tick, half, mode_press, inc_press;
  logic sec_step, min_step, hour_step, leave_set;

  // Increment a BCD tens/units pair, wrapping to 00 after t_max/u_max.
  function automatic logic [7:0] bcd_inc(input logic [3:0] t, input logic [3:0] u,
                                         input logic [3:0] t_max, input logic [3:0] u_max);
    if (t == t_max && u == u_max) return 8'h00;
    else if (u == 4'd9)           return {t + 4'd1, 4'd0};
    else                          return {t, u + 4'd1};
  endfunction

  assign tick = (pre_reg == TICK_VAL);
  assign half = (pre_reg >= HALF_VAL);

  // boot_reg masks the first cycle after reset so a button held through reset
  // is seen as already pressed rather than as a fresh edge.
  assign mode_press = KEY_MODE & ~mode_prev_reg & ~boot_reg;
  assign inc_press  = KEY_INC & ~inc_prev_reg & ~boot_reg & ~mode_press;

  assign sec_step  = (state_reg == RUN) && tick;
  assign min_step  = (sec_step && sc_t_reg == 4'd5 && sc_u_reg == 4'd9) ||
                     (state_reg == SET_MIN && inc_press);
  assign hour_step = (state_reg == RUN && min_step && mn_t_reg == 4'd5 && mn_u_reg == 4'd9) ||
                     (state_reg == SET_HOUR && inc_press);
  assign leave_set = (state_reg == SET_MIN) && mode_press;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_reg     <= RUN;
      pre_reg       <= '0;
      hr_t_reg      <= 4'd0;
      hr_u_reg      <= 4'd0;
      mn_t_reg      <= 4'd0;
      mn_u_reg      <= 4'd0;
      sc_t_reg      <= 4'd0;
      sc_u_reg      <= 4'd0;
      mode_prev_reg <= 1'b0;
      inc_prev_reg  <= 1'b0;
      boot_reg      <= 1'b1;
    end else begin
      state_reg     <= state_next;
      pre_reg       <= pre_next;
      hr_t_reg      <= hr_t_next;
      hr_u_reg      <= hr_u_next;
      mn_t_reg      <= mn_t_next;
      mn_u_reg      <= mn_u_next;
      sc_t_reg      <= sc_t_next;
      sc_u_reg      <= sc_u_next;
      mode_prev_reg <= KEY_MODE;
      inc_prev_reg  <= KEY_INC;
      boot_reg      <= 1'b0;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      RUN:      if (mode_press) state_next = SET_HOUR;
      SET_HOUR: if (mode_press) state_next = SET_MIN;
      SET_MIN:  if (mode_press) state_next = RUN;
      default:  state_next = RUN;
    endcase
  end

  always_comb begin
    pre_next               = tick ? '0 : pre_reg + PW'(1);
    {hr_t_next, hr_u_next} = {hr_t_reg, hr_u_reg};
    {mn_t_next, mn_u_next} = {mn_t_reg, mn_u_reg};
    {sc_t_next, sc_u_next} = {sc_t_reg, sc_u_reg};
    if (sec_step)  {sc_t_next, sc_u_next} = bcd_inc(sc_t_reg, sc_u_reg, 4'd5, 4'd9);
    if (min_step)  {mn_t_next, mn_u_next} = bcd_inc(mn_t_reg, mn_u_reg, 4'd5, 4'd9);
    if (hour_step) {hr_t_next, hr_u_next} = bcd_inc(hr_t_reg, hr_u_reg, 4'd2, 4'd3);
    // Leaving SET_MIN restarts the second so the first tick is a full period away.
    if (leave_set) begin
      {sc_t_next, sc_u_next} = 8'h00;
      pre_next               = '0;
    end
  end

  always_comb begin
    DIG3  = hr_t_reg;
    DIG2  = hr_u_reg;
    DIG1  = mn_t_reg;
    DIG0  = mn_u_reg;
    COLON = 1'b1;
    MODE  = state_reg;
    if (state_reg == RUN) begin
      COLON = ~half;
      if (DISP) {DIG3, DIG2, DIG1, DIG0} = {mn_t_reg, mn_u_reg, sc_t_reg, sc_u_reg};
    end
    if (state_reg == SET_HOUR && half) {DIG3, DIG2} = 8'hFF;
    if (state_reg == SET_MIN && half)  {DIG1, DIG0} = 8'hFF;
  end

endmodule

// File: tb/tb_clock_ctrl.sv
// Randomized and directed bench for clock_ctrl with CLK_HZ=4, checked against
// a time-in-seconds reference model.
module tb_clock_ctrl;
  localparam int HZ = 4;

  logic       clk = 1'b0;
  logic       rst, key_mode, key_inc, disp;
  logic [3:0] dig3, dig2, dig1, dig0;
  logic       colon;
  logic [1:0] mode;
  wire [18:0] obs = {dig3, dig2, dig1, dig0, colon, mode};

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model state: plain integers for hours/minutes/seconds.
  int m_state, m_h, m_m, m_s, m_pre;
  bit m_pm, m_pi;

  always #5 clk = ~clk;

  clock_ctrl #(.CLK_HZ(HZ)) dut (
    .CLK(clk), .RST(rst), .KEY_MODE(key_mode), .KEY_INC(key_inc), .DISP(disp),
    .DIG3(dig3), .DIG2(dig2), .DIG1(dig1), .DIG0(dig0), .COLON(colon), .MODE(mode)
  );

  task automatic model_step(input bit r, input bit km, input bit ki);
    bit mp, ip, tk, clr;
    int t;
    if (r) begin
      m_state = 0; m_h = 0; m_m = 0; m_s = 0; m_pre = 0;
      m_pm = 1'b1; m_pi = 1'b1;   // held buttons must not count as presses
    end else begin
      mp  = km && !m_pm;
      ip  = ki && !m_pi && !mp;
      tk  = (m_pre == HZ - 1);
      clr = 1'b0;
      case (m_state)
        0: begin
          if (tk) begin
            t = (m_h * 3600 + m_m * 60 + m_s + 1) % 86400;
            m_h = t / 3600; m_m = (t / 60) % 60; m_s = t % 60;
          end
          if (mp) m_state = 1;
        end
        1: if (mp) m_state = 2; else if (ip) m_h = (m_h + 1) % 24;
        2: if (mp) begin m_state = 0; m_s = 0; clr = 1'b1; end
           else if (ip) m_m = (m_m + 1) % 60;
        default: ;
      endcase
      m_pre = clr ? 0 : (m_pre + 1) % HZ;
      m_pm  = km;
      m_pi  = ki;
    end
  endtask

  function automatic logic [18:0] exp_out();
    logic [3:0] d3, d2, d1, d0;
    bit half;
    half = (m_pre >= HZ / 2);
    if (m_state == 0 && disp) begin
      d3 = 4'(m_m / 10); d2 = 4'(m_m % 10); d1 = 4'(m_s / 10); d0 = 4'(m_s % 10);
    end else begin
      d3 = 4'(m_h / 10); d2 = 4'(m_h % 10); d1 = 4'(m_m / 10); d0 = 4'(m_m % 10);
    end
    if (m_state == 1 && half) begin d3 = 4'hF; d2 = 4'hF; end
    if (m_state == 2 && half) begin d1 = 4'hF; d0 = 4'hF; end
    return {d3, d2, d1, d0, (m_state == 0) ? !half : 1'b1, 2'(m_state)};
  endfunction

  task automatic step(input bit r, input bit km, input bit ki, input bit d);
    @(negedge clk);
    rst = r; key_mode = km; key_inc = ki; disp = d;
    @(posedge clk);
    model_step(r, km, ki);
    #1;
  endtask

  task automatic test_reset();
    step(1, 0, 0, 0);
    n_cmp++;
    if (obs !== 19'h00004) begin
      n_bad++; $display("FAIL reset_outputs: got %h expected %h", obs, 19'h00004);
    end
    n_cmp++;
    if (obs !== exp_out()) begin
      n_bad++; $display("FAIL reset_model: got %h expected %h", obs, exp_out());
    end
  endtask

  task automatic test_tick();
    bit exp_c[4] = '{1'b1, 1'b0, 1'b0, 1'b1};
    for (int i = 0; i < 4; i++) begin
      step(0, 0, 0, 1);
      n_cmp++;
      if (colon !== exp_c[i]) begin
        n_bad++; $display("FAIL tick_colon%0d: got %b expected %b", i, colon, exp_c[i]);
      end
    end
    n_cmp++;
    if ({dig3, dig2, dig1, dig0} !== 16'h0001) begin
      n_bad++; $display("FAIL tick_first_second: got %h expected 0001", {dig3, dig2, dig1, dig0});
    end
  endtask

  task automatic test_set_time();
    step(0, 1, 0, 0); step(0, 0, 0, 0);
    for (int i = 0; i < 23; i++) begin step(0, 0, 1, 0); step(0, 0, 0, 0); end
    step(0, 1, 0, 0); step(0, 0, 0, 0);
    for (int i = 0; i < 59; i++) begin step(0, 0, 1, 0); step(0, 0, 0, 0); end
    n_cmp++;
    if (obs !== exp_out()) begin
      n_bad++; $display("FAIL set_time_in_set: got %h expected %h", obs, exp_out());
    end
    step(0, 1, 0, 0);
    for (int i = 0; i < 59 * HZ; i++) begin
      step(0, 0, 0, 0);
      n_cmp++;
      if (obs !== exp_out()) begin
        n_bad++; $display("FAIL set_time_run%0d: got %h expected %h", i, obs, exp_out());
      end
    end
    n_cmp++;
    if ({dig3, dig2, dig1, dig0} !== 16'h2359) begin
      n_bad++; $display("FAIL set_time_hhmm: got %h expected 2359", {dig3, dig2, dig1, dig0});
    end
    disp = 1'b1; #1;
    n_cmp++;
    if ({dig3, dig2, dig1, dig0} !== 16'h5959) begin
      n_bad++; $display("FAIL set_time_mmss: got %h expected 5959", {dig3, dig2, dig1, dig0});
    end
    for (int i = 0; i < HZ; i++) step(0, 0, 0, 0);
    n_cmp++;
    if ({dig3, dig2, dig1, dig0} !== 16'h0000) begin
      n_bad++; $display("FAIL midnight_hhmm: got %h expected 0000", {dig3, dig2, dig1, dig0});
    end
    disp = 1'b1; #1;
    n_cmp++;
    if ({dig3, dig2, dig1, dig0} !== 16'h0000) begin
      n_bad++; $display("FAIL midnight_mmss: got %h expected 0000", {dig3, dig2, dig1, dig0});
    end
  endtask

  task automatic test_hour_wrap();
    step(0, 1, 0, 0); step(0, 0, 0, 0);
    for (int i = 0; i < 25; i++) begin step(0, 0, 1, 1); step(0, 0, 0, 1); end
    for (int i = 0; i < HZ; i++) begin
      step(0, 0, 0, 1);
      n_cmp++;
      if ({dig3, dig2} !== ((m_pre >= HZ / 2) ? 8'hFF : 8'h01) || colon !== 1'b1 || mode !== 2'd1) begin
        n_bad++; $display("FAIL hour_wrap%0d: got %h%h colon %b mode %0d expected %h colon 1 mode 1",
                          i, dig3, dig2, colon, mode, (m_pre >= HZ / 2) ? 8'hFF : 8'h01);
      end
    end
  endtask

  task automatic test_min_wrap();
    step(0, 1, 0, 0); step(0, 0, 0, 0);
    for (int i = 0; i < 59; i++) begin step(0, 0, 1, 0); step(0, 0, 0, 0); end
    n_cmp++;
    if (obs !== exp_out()) begin
      n_bad++; $display("FAIL min_59: got %h expected %h", obs, exp_out());
    end
    step(0, 0, 1, 0);
    n_cmp++;
    if ({dig3, dig2} !== 8'h01 || {dig1, dig0} !== ((m_pre >= HZ / 2) ? 8'hFF : 8'h00)) begin
      n_bad++; $display("FAIL min_wrap: got %h%h%h%h expected hours 01 minutes 00", dig3, dig2, dig1, dig0);
    end
    step(0, 0, 0, 1);
    step(0, 1, 0, 1);
    n_cmp++;
    if (mode !== 2'd0 || {dig3, dig2, dig1, dig0} !== 16'h0000) begin
      n_bad++; $display("FAIL back_to_run: got mode %0d digits %h expected mode 0 digits 0000",
                        mode, {dig3, dig2, dig1, dig0});
    end
    for (int i = 1; i <= HZ; i++) begin
      step(0, 0, 0, 1);
      n_cmp++;
      if ({dig3, dig2, dig1, dig0} !== ((i == HZ) ? 16'h0001 : 16'h0000)) begin
        n_bad++; $display("FAIL first_tick%0d: got %h expected %h", i, {dig3, dig2, dig1, dig0},
                          (i == HZ) ? 16'h0001 : 16'h0000);
      end
    end
  endtask

  task automatic test_simultaneous();
    step(0, 1, 0, 0); step(0, 0, 0, 0);
    step(0, 1, 1, 0);
    n_cmp++;
    if (mode !== 2'd2 || {dig3, dig2} !== 8'h01) begin
      n_bad++; $display("FAIL simul_press: got mode %0d hours %h%h expected mode 2 hours 01", mode, dig3, dig2);
    end
    step(0, 0, 0, 0);
    for (int i = 0; i < 10; i++) step(0, 0, 1, 0);
    step(0, 0, 0, 0);
    for (int i = 0; i < HZ && m_pre >= HZ / 2; i++) step(0, 0, 0, 0);
    n_cmp++;
    if ({dig1, dig0} !== 8'h01) begin
      n_bad++; $display("FAIL held_inc: got minutes %h%h expected 01", dig1, dig0);
    end
  endtask

  task automatic test_reset_held();
    step(1, 1, 0, 0);
    for (int i = 0; i < 5; i++) begin
      step(0, 1, 0, 0);
      n_cmp++;
      if (mode !== 2'd0 || {dig3, dig2, dig1, dig0} !== 16'h0000) begin
        n_bad++; $display("FAIL reset_held%0d: got mode %0d digits %h expected mode 0 digits 0000",
                          i, mode, {dig3, dig2, dig1, dig0});
      end
    end
    step(0, 0, 0, 0);
    step(0, 1, 0, 0);
    n_cmp++;
    if (mode !== 2'd1) begin
      n_bad++; $display("FAIL reset_rearm: got mode %0d expected 1", mode);
    end
    step(0, 0, 0, 0);
  endtask

  task automatic test_random();
    bit r, km, ki, d;
    step(1, 0, 0, 0);
    for (int i = 0; i < 3000; i++) begin
      r  = ($urandom_range(0, 499) == 0);
      km = ($urandom_range(0, 15) == 0);
      ki = ($urandom_range(0, 4) == 0);
      d  = 1'($urandom_range(0, 1));
      step(r, km, ki, d);
      n_cmp++;
      if (obs !== exp_out()) begin
        n_bad++; $display("FAIL random%0d: got %h expected %h", i, obs, exp_out());
      end
    end
  endtask

  initial begin
    rst = 1'b1; key_mode = 1'b0; key_inc = 1'b0; disp = 1'b0;
    test_reset();
    test_tick();
    test_set_time();
    test_hour_wrap();
    test_min_wrap();
    test_simultaneous();
    test_reset_held();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
